spi_rdid_responder: RTL and testbench

- SPI mode-0 flash-side responder for the JEDEC Read Identification (RDID) command.
- Answers opcode 0x9F with manufacturer ID, memory type and memory capacity, MSB first.
- Serves as the flash stand-in in simulation and on-board loopback tests of the RDID initiator and LED display path.
- Runs in the system clock domain and oversamples the SPI lines.

---
 rtl/spi_rdid_responder.sv | 179 +++++++++++++++++
 tb/tb_spi_rdid_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_rdid_responder.sv
// rtl/spi_rdid_responder.sv - SPI mode-0 flash-side responder for the JEDEC RDID command.
// Oversamples sclk/cs_n/mosi in the clk domain and shifts the three ID bytes out MSB first.
module spi_rdid_responder #(
  parameter logic [7:0] RDID_OPCODE = 8'h9F,
  parameter logic [7:0] MFG_ID      = 8'h20,
  parameter logic [7:0] MEM_TYPE    = 8'h20,
  parameter logic [7:0] MEM_CAP     = 8'h18,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       cmd_done,
  output logic [7:0] last_cmd,
  output logic [7:0] rdid_count
);

  typedef enum logic [1:0] {IDLE, CMD, ID_OUT, IGNORE} state_t;

  state_t     state_q, state_d;
  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_dly_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] cmd_sr_q, cmd_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic       skip_fall_q, skip_fall_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;
  logic       cmd_done_q, cmd_done_d;
  logic [7:0] last_cmd_q, last_cmd_d;
  logic [7:0] rdid_count_q, rdid_count_d;

  logic       sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
  logic [7:0] cmd_byte;
  logic [1:0] next_idx;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cmd_byte  = {cmd_sr_q[6:0], mosi_s};
  assign next_idx  = (byte_idx_q == 2'd3) ? 2'd3 : byte_idx_q + 2'd1;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = MFG_ID;
      2'd1:    id_byte = MEM_TYPE;
      2'd2:    id_byte = MEM_CAP;
      default: id_byte = FILL_BYTE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (sclk_rise && bit_cnt_q == 3'd7)
                   state_d = (cmd_byte == RDID_OPCODE) ? ID_OUT : IGNORE;
        default: state_d = state_q;
      endcase
    end
  end

  // The fall right after the last command bit must not shift: MSB was driven on entry.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    cmd_sr_d     = cmd_sr_q;
    tx_sr_d      = tx_sr_q;
    byte_idx_d   = byte_idx_q;
    skip_fall_d  = skip_fall_q;
    cmd_done_d   = 1'b0;
    last_cmd_d   = last_cmd_q;
    rdid_count_d = rdid_count_q;
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = 3'd0;
          cmd_sr_d  = 8'h00;
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_sr_d  = cmd_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              last_cmd_d = cmd_byte;
              cmd_done_d = 1'b1;
              if (cmd_byte == RDID_OPCODE) begin
                rdid_count_d = rdid_count_q + 8'd1;
                tx_sr_d      = MFG_ID;
                byte_idx_d   = 2'd0;
                skip_fall_d  = 1'b1;
              end
            end
          end
        end
        ID_OUT: begin
          if (sclk_fall) begin
            if (skip_fall_q) begin
              skip_fall_d = 1'b0;
            end else if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              byte_idx_d = next_idx;
              tx_sr_d    = id_byte(next_idx);
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_sr_d   = {tx_sr_q[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    miso_oe_d = (state_d == ID_OUT);
    miso_d    = miso_oe_d ? tx_sr_d[7] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync_q  <= 2'b00;
      cs_sync_q    <= 2'b11;
      mosi_sync_q  <= 2'b00;
      sclk_dly_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      cmd_sr_q     <= 8'h00;
      tx_sr_q      <= 8'h00;
      byte_idx_q   <= 2'd0;
      skip_fall_q  <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      cmd_done_q   <= 1'b0;
      last_cmd_q   <= 8'h00;
      rdid_count_q <= 8'h00;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[0], sclk};
      cs_sync_q    <= {cs_sync_q[0], cs_n};
      mosi_sync_q  <= {mosi_sync_q[0], mosi};
      sclk_dly_q   <= sclk_s;
      bit_cnt_q    <= bit_cnt_d;
      cmd_sr_q     <= cmd_sr_d;
      tx_sr_q      <= tx_sr_d;
      byte_idx_q   <= byte_idx_d;
      skip_fall_q  <= skip_fall_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      cmd_done_q   <= cmd_done_d;
      last_cmd_q   <= last_cmd_d;
      rdid_count_q <= rdid_count_d;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign cmd_done   = cmd_done_q;
  assign last_cmd   = last_cmd_q;
  assign rdid_count = rdid_count_q;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// tb/tb_spi_rdid_responder.sv - directed bench for spi_rdid_responder with a byte scoreboard.
module tb_spi_rdid_responder;

  logic       clk = 1'b0;
  logic       reset_n, sclk, cs_n, mosi;
  logic       miso, miso_oe, cmd_done;
  logic [7:0] last_cmd, rdid_count;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic       oe_seen = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdid = 8'h00;
  logic [7:0] rx;

  always #5 clk = ~clk;

  spi_rdid_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .cmd_done   (cmd_done),
    .last_cmd   (last_cmd),
    .rdid_count (rdid_count)
  );

  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (miso_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxo);
    rxo = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      wait_clk(5);
      rxo = {rxo[6:0], miso};
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_rdid();
    logic [7:0] dummy;
    spi_bits(8'h9F, 8, dummy);
    exp_rdid = exp_rdid + 8'd1;
  endtask

  task automatic read_check(input string tag);
    logic [7:0] got, exp;
    spi_bits(8'h00, 8, got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, got);
    end else begin
      exp = exp_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(1);
    check("rst_miso", {7'd0, miso}, 8'h00);
    check("rst_oe", {7'd0, miso_oe}, 8'h00);
    check("rst_done", {7'd0, cmd_done}, 8'h00);
    check("rst_last_cmd", last_cmd, 8'h00);
    check("rst_rdid_count", rdid_count, 8'h00);

    // basic RDID
    done_cnt = 0;
    cs_low();
    send_rdid();
    exp_q.push_back(8'h20); exp_q.push_back(8'h20); exp_q.push_back(8'h18);
    read_check("t1_mfg");
    read_check("t1_type");
    read_check("t1_cap");
    cs_high();
    check("t1_done_cnt", done_cnt[7:0], 8'd1);
    check("t1_last_cmd", last_cmd, 8'h9F);
    check("t1_rdid_count", rdid_count, exp_rdid);

    // fill bytes beyond the ID
    cs_low();
    send_rdid();
    exp_q.push_back(8'h20); exp_q.push_back(8'h20); exp_q.push_back(8'h18);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    read_check("t2_b0");
    read_check("t2_b1");
    read_check("t2_b2");
    read_check("t2_fill0");
    read_check("t2_fill1");
    check("t2_oe_held", {7'd0, miso_oe}, 8'h01);
    cs_n = 1'b1;
    wait_clk(4);
    check("t2_oe_drop", {7'd0, miso_oe}, 8'h00);
    wait_clk(2);
    check("t2_rdid_count", rdid_count, exp_rdid);

    // non-RDID opcode
    done_cnt = 0;
    oe_seen = 1'b0;
    cs_low();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hA5, 8, rx);
    cs_high();
    check("t3_done_cnt", done_cnt[7:0], 8'd1);
    check("t3_last_cmd", last_cmd, 8'h03);
    check("t3_oe_seen", {7'd0, oe_seen}, 8'h00);
    check("t3_rdid_count", rdid_count, exp_rdid);

    // partial byte discarded by cs_n
    done_cnt = 0;
    cs_low();
    spi_bits(8'h9F, 5, rx);
    cs_high();
    check("t4_no_done", done_cnt[7:0], 8'd0);
    cs_low();
    send_rdid();
    exp_q.push_back(8'h20);
    read_check("t4_mfg");
    cs_high();
    check("t4_done_cnt", done_cnt[7:0], 8'd1);
    check("t4_rdid_count", rdid_count, exp_rdid);

    // abort mid-byte 2 then restart
    cs_low();
    send_rdid();
    exp_q.push_back(8'h20);
    read_check("t5_mfg");
    spi_bits(8'h00, 4, rx);
    cs_n = 1'b1;
    wait_clk(4);
    check("t5_oe_drop", {7'd0, miso_oe}, 8'h00);
    wait_clk(2);
    cs_low();
    send_rdid();
    exp_q.push_back(8'h20);
    read_check("t5_restart_mfg");
    cs_high();
    check("t5_rdid_count", rdid_count, exp_rdid);

    // counter wrap
    while (exp_rdid != 8'h00) begin
      cs_low();
      send_rdid();
      cs_high();
    end
    check("t6_rdid_wrap", rdid_count, exp_rdid);

    // reset pulse during ID_OUT
    cs_low();
    send_rdid();
    spi_bits(8'h00, 4, rx);
    check("t6_oe_before_rst", {7'd0, miso_oe}, 8'h01);
    reset_n = 1'b0;
    wait_clk(1);
    reset_n = 1'b1;
    check("t6_rst_miso", {7'd0, miso}, 8'h00);
    check("t6_rst_oe", {7'd0, miso_oe}, 8'h00);
    check("t6_rst_done", {7'd0, cmd_done}, 8'h00);
    check("t6_rst_last_cmd", last_cmd, 8'h00);
    check("t6_rst_rdid_count", rdid_count, 8'h00);
    cs_high();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
